// File: rtl/pc_src_pkg.sv
// Shared types and constants for the PC-source unit: FSM states and fault cause codes.
package pc_src_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        FAULT = 2'b10
    } pc_state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_SEL   = 2'b01;
    localparam logic [1:0] ERR_ALIGN = 2'b10;

endpackage

// File: rtl/pc_src_mux.sv
// Combinational NUM_SRC-way selector over a flattened source bus.
// An out-of-range select yields zero so downstream logic never sees stale data.
module pc_src_mux #(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 6,
    parameter int SEL_W   = 4
) (
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [SEL_W-1:0]          src_sel,
    output logic [DATA_W-1:0]         mux_out
);

    // Pick the source whose index matches the select; default to zero when none matches.
    always_comb begin
        mux_out = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (src_sel == SEL_W'(k)) begin
                mux_out = src_data[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/pc_source_unit.sv
// PC-source unit: selects the next PC from NUM_SRC candidates and owns the PC register,
// with conditional write, previous-PC capture, update pulse and a sticky fault state.
module pc_source_unit
    import pc_src_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                NUM_SRC   = 6,
    parameter int                SEL_W     = 4,
    parameter logic [DATA_W-1:0] RESET_PC  = '0,
    parameter bit                ALIGN_CHK = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [SEL_W-1:0]          src_sel,
    input  logic                      pc_write,
    input  logic                      pc_write_cond,
    input  logic                      cond_true,
    input  logic                      err_clr,
    output logic [DATA_W-1:0]         mux_out,
    output logic [DATA_W-1:0]         pc_out,
    output logic [DATA_W-1:0]         pc_prev,
    output logic                      pc_upd,
    output logic                      pc_valid,
    output logic [1:0]                err_cause
);

    localparam logic [SEL_W:0] NUM_SRC_EXT = (SEL_W+1)'(NUM_SRC);

    pc_state_t   state;
    pc_state_t   state_nxt;
    logic        upd;
    logic        sel_bad;
    logic        misaligned;
    logic        load_pc;
    logic [1:0]  cause_nxt;

    pc_src_mux #(
        .DATA_W  (DATA_W),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_mux (
        .src_data (src_data),
        .src_sel  (src_sel),
        .mux_out  (mux_out)
    );

    // A plain write always counts; a conditional write only when its branch condition holds.
    assign upd        = pc_write | (pc_write_cond & cond_true);
    assign sel_bad    = ({1'b0, src_sel} >= NUM_SRC_EXT);
    assign misaligned = ALIGN_CHK && (mux_out[1:0] != 2'b00);
    assign pc_valid   = (state != BOOT);

    // Next-state and load decision; an illegal select is checked first so it wins over misalignment.
    always_comb begin
        state_nxt = state;
        load_pc   = 1'b0;
        cause_nxt = err_cause;
        case (state)
            BOOT: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (upd) begin
                    if (sel_bad) begin
                        state_nxt = FAULT;
                        cause_nxt = ERR_SEL;
                    end else if (misaligned) begin
                        state_nxt = FAULT;
                        cause_nxt = ERR_ALIGN;
                    end else begin
                        load_pc = 1'b1;
                    end
                end
            end
            FAULT: begin
                if (err_clr) begin
                    state_nxt = RUN;
                    cause_nxt = ERR_NONE;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // PC, previous-PC, update pulse and fault cause registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_out    <= RESET_PC;
            pc_prev   <= RESET_PC;
            pc_upd    <= 1'b0;
            err_cause <= ERR_NONE;
        end else begin
            pc_upd    <= load_pc;
            err_cause <= cause_nxt;
            if (load_pc) begin
                pc_prev <= pc_out;
                pc_out  <= mux_out;
            end
        end
    end

endmodule
